// File: rtl/unary_mac_pkg.sv
// Shared types and default widths for the unary shift MAC sequencer.
package unary_mac_pkg;

   localparam int UNARY_W     = 4;
   localparam int UNARY_ACC_W = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } ctrl_state_t;

endpackage

// File: rtl/unary_stream_gen.sv
// Thermometer bitstream generator: a 2^W-cycle counter compared against the
// stream operand, with a terminal-count flag on the final cycle.
module unary_stream_gen
   import unary_mac_pkg::*;
#(
   parameter int W = UNARY_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         enable,
   input  logic [W-1:0] a,
   output logic         stream_bit,
   output logic         last_cycle
);

   logic [W-1:0] cnt;

   // Natural W-bit wrap returns cnt to 0 after the L-1 cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign stream_bit = (cnt < a);
   assign last_cycle = (cnt == {W{1'b1}});

endmodule

// File: rtl/unary_mac_ctrl.sv
// Unary shift MAC sequencer: streams a thermometer code of a, accumulates b
// per '1' bit across a group. Optional saturation: UNARY_MAC_CTRL_SAT_EN.
//
// state  | meaning
// IDLE   | ready for an operand pair
// CLEAR  | first pair of a group: clear capture register and accumulator
// STREAM | L cycles of thermometer bits, accumulating b on each '1'
// DONE   | group result presented until out_ready
module unary_mac_ctrl
   import unary_mac_pkg::*;
#(
   parameter int W     = UNARY_W,
   parameter int ACC_W = UNARY_ACC_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic             in_last,
   output logic             sipo_in,
   output logic             sipo_shift,
   output logic             sipo_clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             ovf
);

   ctrl_state_t      state;
   ctrl_state_t      state_next;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic             last_q;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_add;
   logic             first;
   logic             accept;
   logic             stream_bit;
   logic             last_cycle;

   assign accept = in_valid && (state == IDLE);

   unary_stream_gen #(
      .W(W)
   ) u_stream_gen (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (accept),
      .enable     (state == STREAM),
      .a          (a_q),
      .stream_bit (stream_bit),
      .last_cycle (last_cycle)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      sipo_in    = 1'b0;
      sipo_shift = 1'b0;
      sipo_clear = 1'b0;
      out_valid  = 1'b0;
      out_acc    = '0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = first ? CLEAR : STREAM;
            end
         end
         CLEAR: begin
            sipo_clear = 1'b1;
            state_next = STREAM;
         end
         STREAM: begin
            sipo_shift = 1'b1;
            sipo_in    = stream_bit;
            if (last_cycle) begin
               state_next = last_q ? DONE : IDLE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            out_acc   = acc;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef UNARY_MAC_CTRL_SAT_EN
   logic [ACC_W:0] acc_sum;
   logic           ovf_q;

   assign acc_sum = {1'b0, acc} + {{(ACC_W + 1 - W){1'b0}}, b_q};
   assign acc_add = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];

   // Sticky within a group; only CLEAR or reset drops it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ovf_q <= 1'b0;
      end else if (state == CLEAR) begin
         ovf_q <= 1'b0;
      end else if ((state == STREAM) && stream_bit && acc_sum[ACC_W]) begin
         ovf_q <= 1'b1;
      end
   end

   assign ovf = ovf_q;
`else
   assign acc_add = acc + {{(ACC_W - W){1'b0}}, b_q};
   assign ovf     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_q    <= '0;
         b_q    <= '0;
         last_q <= 1'b0;
         acc    <= '0;
         first  <= 1'b1;
      end else begin
         if (accept) begin
            a_q    <= in_a;
            b_q    <= in_b;
            last_q <= in_last;
         end
         case (state)
            CLEAR: begin
               acc   <= '0;
               first <= 1'b0;
            end
            STREAM: begin
               if (stream_bit) begin
                  acc <= acc_add;
               end
            end
            DONE: begin
               if (out_ready) begin
                  first <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/unary_mac_ctrl.md
Name: unary_mac_ctrl

Overview:
Sequencer for the unary shift MAC datapath.
- Accepts (a, b) operand pairs over a valid/ready handshake.
- For each pair, generates a 2^W-cycle thermometer bitstream of a. This stream drives an external serial-in/parallel-out capture register through its in/shift/clear controls.
- Accumulates b on every '1' bit, so the accumulator gains a*b per pair.
- Sums pairs across a group terminated by a last flag, then presents the result with valid/ready.

Parameters:
- W, 4, operand width; stream length L = 2^W cycles per pair.
- ACC_W, 12, accumulator/result width; must be >= 2*W.

Ports:
- clk  input  1  clock.
- reset_n  input  1  reset; synchronous, active-low. Sampled only on the rising edge of clk.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept a pair.
- in_a  input  W  stream operand, unsigned.
- in_b  input  W  weight operand, unsigned.
- in_last  input  1  this pair closes the accumulation group.
- sipo_in  output  1  serial data bit to the capture register.
- sipo_shift  output  1  shift enable to the capture register.
- sipo_clear  output  1  clear to the capture register.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed.
- out_acc  output  ACC_W  accumulated group result.
- ovf  output  1  sticky overflow flag for the current group; tied 0 unless the optional feature is compiled in.

Behaviour:
- State machine: IDLE, CLEAR, STREAM, DONE.
- Registers:
  - state
  - cnt (W bits)
  - a_q, b_q, last_q
  - acc (ACC_W bits)
  - first: set means the next accepted pair starts a new group.
- Output timing: all outputs are decodes of registered state only. There is no combinational input-to-output path.
- Reset: when reset_n is low at a clk edge, the block goes to IDLE with cnt=0, acc=0, first=1, ovf=0. Reset takes effect from any state, including mid-STREAM.
- Output values in reset/IDLE:
  - in_ready=1
  - sipo_in=0, sipo_shift=0, sipo_clear=0
  - out_valid=0
  - out_acc=0
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a_q, b_q and last_q; set cnt=0.
  - Next state is CLEAR if first=1, else STREAM.
- CLEAR (exactly 1 cycle):
  - sipo_clear=1, sipo_shift=0.
  - acc<=0, ovf<=0, first<=0.
  - Next state: STREAM.
- STREAM (exactly L cycles):
  - sipo_shift=1, sipo_in=(cnt < a_q).
  - When the bit is 1: acc <= acc + b_q, modulo 2^ACC_W.
  - cnt increments each cycle.
  - At cnt == L-1: cnt wraps to 0. Next state is DONE if last_q, else IDLE.
- DONE:
  - out_valid=1, out_acc=acc, held stable until out_ready.
  - in_ready=0.
  - On out_ready: set first=1 and go to IDLE. out_acc reads 0 from IDLE onward.
- Thermometer range: a=0 produces L zero bits. a=2^W-1 produces L-1 ones followed by one zero.
- Per-pair latency:
  - 1 accept cycle + 1 CLEAR cycle (first pair of a group only) + L STREAM cycles.
  - out_valid rises on the cycle after the last STREAM cycle.
- Simultaneous events: in DONE, a pending in_valid waits because in_ready=0. The pair is accepted in IDLE, at the earliest the cycle after out_ready.

Optional Feature:
Macro: UNARY_MAC_CTRL_SAT_EN
- Defined:
  - acc saturates at 2^ACC_W-1 instead of wrapping.
  - ovf goes to 1 on the first saturating add and stays 1 until the next CLEAR or reset.
  - ovf is valid alongside out_acc in DONE.
- Undefined: acc wraps modulo 2^ACC_W and ovf is constant 0.

Decomposition:
- Package unary_mac_pkg holds:
  - state enum type ctrl_state_t {IDLE, CLEAR, STREAM, DONE}
  - default constants UNARY_W=4 and UNARY_ACC_W=12.
- One sub-module: unary_stream_gen. It contains cnt, the comparator (cnt < a_q), and the terminal-count flag. It takes start and enable inputs and produces bit and last_cycle outputs.

Test Plan:
1. Reset, then one pair a=3, b=5, last=1.
   - Expect sipo_clear=1 for 1 cycle, then sipo_shift=1 for 16 cycles.
   - sipo_in pattern: 1,1,1 followed by 13 zeros.
   - out_valid=1 with out_acc=15.
2. Group of three pairs (2,7), (15,15), (0,9), last set on the third.
   - sipo_clear fires only before the first pair.
   - out_acc=14+225+0=239.
3. Backpressure: out_ready=0 for 10 cycles in DONE while in_valid=1.
   - out_valid and out_acc stay stable; in_ready=0.
   - After out_ready, the next pair is accepted one cycle later.
4. reset_n low for one edge mid-STREAM (cnt=7).
   - Next cycle: IDLE, all outputs at reset values, acc=0.
   - Reset_n pulsed low between edges has no effect.
5. ACC_W=8, pairs (15,15) then (15,15) with last.
   - Without the macro: out_acc=450 mod 256=194, ovf=0.
   - With UNARY_MAC_CTRL_SAT_EN: out_acc=255, ovf=1.
6. a=0, b=15, last=1.
   - 16 shift cycles with sipo_in=0 throughout; out_acc=0.
